debounce_multi: RTL and testbench

Parametrised N-channel switch/button debouncer for the Basys3 top level, replacing the single-channel debouncer. Each channel has a 2-flop synchroniser, a stability counter, a debounced level, one-cycle rise/fall pulses and a settling (bounce) indicator. An optional per-channel saturating bounce-event counter supports board bring-up. It sits between the raw button/switch pins and downstream logic, which consumes only the clean levels and pulses.

---
 rtl/debounce_multi.sv | 133 +++++++++++++
 tb/tb_debounce_multi.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel debouncer (2-flop sync, stability FSM, edge pulses).
// Define DEBOUNCE_BOUNCE_CNT_EN to build per-channel saturating bounce counters.
module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     raw,
  input  logic                clr_cnt,
  output logic [N_CH-1:0]     clean,
  output logic [N_CH-1:0]     rise,
  output logic [N_CH-1:0]     fall,
  output logic [N_CH-1:0]     bounce,
  output logic [8*N_CH-1:0]   bounce_cnt
);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [N_CH-1:0] abort;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             sync1;
    logic             s;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             clean_q;
    logic             clean_n;
    logic             rise_q;
    logic             rise_n;
    logic             fall_q;
    logic             fall_n;
    logic             abort_c;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1   <= 1'b0;
        s       <= 1'b0;
        state   <= STABLE;
        cnt     <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        sync1   <= raw[i];
        s       <= sync1;
        state   <= state_n;
        cnt     <= cnt_n;
        clean_q <= clean_n;
        rise_q  <= rise_n;
        fall_q  <= fall_n;
      end
    end

    // A return to the committed level while settling is a bounce event.
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      clean_n = clean_q;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      abort_c = 1'b0;
      unique case (state)
        STABLE: begin
          if (s != clean_q) begin
            state_n = SETTLING;
            cnt_n   = ONE;
          end else begin
            cnt_n   = '0;
          end
        end
        SETTLING: begin
          unique case (1'b1)
            (s == clean_q): begin
              state_n = STABLE;
              cnt_n   = '0;
              abort_c = 1'b1;
            end
            (s != clean_q && cnt == LAST): begin
              state_n = STABLE;
              cnt_n   = '0;
              clean_n = s;
              rise_n  = s;
              fall_n  = ~s;
            end
            (s != clean_q && cnt != LAST): begin
              cnt_n   = cnt + ONE;
            end
          endcase
        end
      endcase
    end

    assign clean[i]  = clean_q;
    assign rise[i]   = rise_q;
    assign fall[i]   = fall_q;
    assign bounce[i] = (state == SETTLING);
    assign abort[i]  = abort_c;
  end

`ifdef DEBOUNCE_BOUNCE_CNT_EN
  for (genvar i = 0; i < N_CH; i++) begin : g_bcnt
    logic [7:0] bc;

    // Clear has priority over a same-cycle abort.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bc <= '0;
      end else if (clr_cnt) begin
        bc <= '0;
      end else if (abort[i] && bc != 8'hFF) begin
        bc <= bc + 8'd1;
      end
    end

    assign bounce_cnt[8*i +: 8] = bc;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{clr_cnt, abort};
  assign bounce_cnt = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: scoreboard bench for debounce_multi (N_CH=4, STABLE_CYCLES=8).
// Counter expectations follow DEBOUNCE_BOUNCE_CNT_EN.
module tb_debounce_multi;

`ifdef DEBOUNCE_BOUNCE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  raw;
  logic        clr_cnt;
  logic [3:0]  clean;
  logic [3:0]  rise;
  logic [3:0]  fall;
  logic [3:0]  bounce;
  logic [31:0] bounce_cnt;

  int edge_n = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  cl;
    logic [3:0]  ri;
    logic [3:0]  fa;
    logic [3:0]  bo;
    logic [31:0] bc;
    string       tag;
  } exp_t;

  exp_t q[$];

  debounce_multi #(
    .N_CH(4),
    .STABLE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .raw(raw),
    .clr_cnt(clr_cnt),
    .clean(clean),
    .rise(rise),
    .fall(fall),
    .bounce(bounce),
    .bounce_cnt(bounce_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void push(int cyc, logic [3:0] cl, logic [3:0] ri,
                               logic [3:0] fa, logic [3:0] bo,
                               logic [31:0] bc, string tag);
    exp_t e;
    e.cyc = cyc;
    e.cl  = cl;
    e.ri  = ri;
    e.fa  = fa;
    e.bo  = bo;
    e.bc  = bc;
    e.tag = tag;
    q.push_back(e);
  endfunction

  function automatic logic [31:0] bc_ch(int ch, int n);
    logic [31:0] v;
    v = '0;
    if (CNT_EN) v[8*ch +: 8] = 8'(n);
    return v;
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    raw     = 4'b0;
    clr_cnt = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({clean, rise, fall, bounce} !== 16'h0 || bounce_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset: got clean=%b rise=%b fall=%b bounce=%b cnt=%h want all 0",
               clean, rise, fall, bounce, bounce_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({clean, rise, fall, bounce} !== 16'h0) begin
      errors++;
      $display("FAIL reset_release: got clean=%b rise=%b fall=%b bounce=%b want 0",
               clean, rise, fall, bounce);
    end
  endtask

  task automatic test_clean_press();
    int   t0;
    exp_t e;
    t0  = edge_n;
    raw = 4'b0001;
    for (int r = 1; r <= 12; r++)
      push(t0 + r, (r >= 10) ? 4'b0001 : 4'b0, (r == 10) ? 4'b0001 : 4'b0,
           4'b0, (r >= 3 && r <= 9) ? 4'b0001 : 4'b0, 32'h0, "press");
    repeat (12) begin
      @(negedge clk);
      while (q.size() != 0 && q[0].cyc == edge_n) begin
        e = q.pop_front();
        checks++;
        if ({clean, rise, fall, bounce} !== {e.cl, e.ri, e.fa, e.bo} ||
            bounce_cnt !== e.bc) begin
          errors++;
          $display("FAIL %s @%0d: got c=%b r=%b f=%b b=%b n=%h want c=%b r=%b f=%b b=%b n=%h",
                   e.tag, edge_n, clean, rise, fall, bounce, bounce_cnt,
                   e.cl, e.ri, e.fa, e.bo, e.bc);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL press_drain: got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_bounce_burst();
    int   t0;
    int   n;
    exp_t e;
    t0     = edge_n;
    raw[1] = 1'b1;
    for (int r = 1; r <= 42; r++) begin
      n = (r / 6 > 5) ? 5 : r / 6;
      if (r < 30)
        push(t0 + r, 4'b0001, 4'b0, 4'b0, (r % 6 >= 3) ? 4'b0010 : 4'b0,
             bc_ch(1, n), "burst");
      else
        push(t0 + r, (r >= 40) ? 4'b0011 : 4'b0001, (r == 40) ? 4'b0010 : 4'b0,
             4'b0, (r >= 33 && r <= 39) ? 4'b0010 : 4'b0, bc_ch(1, 5), "burst_hold");
    end
    for (int r = 1; r <= 42; r++) begin
      @(negedge clk);
      while (q.size() != 0 && q[0].cyc == edge_n) begin
        e = q.pop_front();
        checks++;
        if ({clean, rise, fall, bounce} !== {e.cl, e.ri, e.fa, e.bo} ||
            bounce_cnt !== e.bc) begin
          errors++;
          $display("FAIL %s @%0d: got c=%b r=%b f=%b b=%b n=%h want c=%b r=%b f=%b b=%b n=%h",
                   e.tag, edge_n, clean, rise, fall, bounce, bounce_cnt,
                   e.cl, e.ri, e.fa, e.bo, e.bc);
        end
      end
      raw[1] = (r >= 30) ? 1'b1 : ((r % 6) < 3);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL burst_drain: got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_simultaneous();
    int   t0;
    exp_t e;
    rst_n = 1'b0;
    raw   = 4'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t0  = edge_n;
    raw = 4'b1111;
    for (int r = 1; r <= 12; r++)
      push(t0 + r, (r >= 10) ? 4'b1111 : 4'b0, (r == 10) ? 4'b1111 : 4'b0,
           4'b0, (r >= 3 && r <= 9) ? 4'b1111 : 4'b0, 32'h0, "simul");
    repeat (12) begin
      @(negedge clk);
      while (q.size() != 0 && q[0].cyc == edge_n) begin
        e = q.pop_front();
        checks++;
        if ({clean, rise, fall, bounce} !== {e.cl, e.ri, e.fa, e.bo} ||
            bounce_cnt !== e.bc) begin
          errors++;
          $display("FAIL %s @%0d: got c=%b r=%b f=%b b=%b n=%h want c=%b r=%b f=%b b=%b n=%h",
                   e.tag, edge_n, clean, rise, fall, bounce, bounce_cnt,
                   e.cl, e.ri, e.fa, e.bo, e.bc);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL simul_drain: got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_release();
    int   t0;
    exp_t e;
    t0  = edge_n;
    raw = 4'b1011;
    for (int r = 1; r <= 12; r++)
      push(t0 + r, (r >= 10) ? 4'b1011 : 4'b1111, 4'b0,
           (r == 10) ? 4'b0100 : 4'b0, (r >= 3 && r <= 9) ? 4'b0100 : 4'b0,
           32'h0, "release");
    repeat (12) begin
      @(negedge clk);
      while (q.size() != 0 && q[0].cyc == edge_n) begin
        e = q.pop_front();
        checks++;
        if ({clean, rise, fall, bounce} !== {e.cl, e.ri, e.fa, e.bo} ||
            bounce_cnt !== e.bc) begin
          errors++;
          $display("FAIL %s @%0d: got c=%b r=%b f=%b b=%b n=%h want c=%b r=%b f=%b b=%b n=%h",
                   e.tag, edge_n, clean, rise, fall, bounce, bounce_cnt,
                   e.cl, e.ri, e.fa, e.bo, e.bc);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL release_drain: got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_reset_mid_settle();
    int   d;
    exp_t e;
    rst_n = 1'b0;
    raw   = 4'b1000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (bounce !== 4'b1000 || clean !== 4'b0) begin
      errors++;
      $display("FAIL mid_settle_pre: got bounce=%b clean=%b want bounce=1000 clean=0000",
               bounce, clean);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({clean, rise, fall, bounce} !== 16'h0 || bounce_cnt !== 32'h0) begin
      errors++;
      $display("FAIL mid_settle_async: got c=%b r=%b f=%b b=%b n=%h want all 0",
               clean, rise, fall, bounce, bounce_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d = edge_n;
    for (int r = 1; r <= 12; r++)
      push(d + r, (r >= 10) ? 4'b1000 : 4'b0, (r == 10) ? 4'b1000 : 4'b0,
           4'b0, (r >= 3 && r <= 9) ? 4'b1000 : 4'b0, 32'h0, "post_reset");
    repeat (12) begin
      @(negedge clk);
      while (q.size() != 0 && q[0].cyc == edge_n) begin
        e = q.pop_front();
        checks++;
        if ({clean, rise, fall, bounce} !== {e.cl, e.ri, e.fa, e.bo} ||
            bounce_cnt !== e.bc) begin
          errors++;
          $display("FAIL %s @%0d: got c=%b r=%b f=%b b=%b n=%h want c=%b r=%b f=%b b=%b n=%h",
                   e.tag, edge_n, clean, rise, fall, bounce, bounce_cnt,
                   e.cl, e.ri, e.fa, e.bo, e.bc);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_drain: got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_saturation();
    int   t0;
    int   n;
    exp_t e;
    for (int k = 1; k <= 302; k++) begin
      t0     = edge_n;
      raw[0] = 1'b1;
      n      = (k <= 300) ? ((k > 255) ? 255 : k) : k - 301;
      push(t0 + 6, 4'b1000, 4'b0, 4'b0, 4'b0, bc_ch(0, n),
           (k == 301) ? "clr_vs_abort" : "sat");
      for (int r = 1; r <= 6; r++) begin
        @(negedge clk);
        while (q.size() != 0 && q[0].cyc == edge_n) begin
          e = q.pop_front();
          checks++;
          if ({clean, rise, fall, bounce} !== {e.cl, e.ri, e.fa, e.bo} ||
              bounce_cnt !== e.bc) begin
            errors++;
            $display("FAIL %s k=%0d: got c=%b r=%b f=%b b=%b n=%h want c=%b r=%b f=%b b=%b n=%h",
                     e.tag, k, clean, rise, fall, bounce, bounce_cnt,
                     e.cl, e.ri, e.fa, e.bo, e.bc);
          end
        end
        if (r == 3) raw[0] = 1'b0;
        if (r == 5 && k == 301) clr_cnt = 1'b1;
        if (r == 6) clr_cnt = 1'b0;
      end
    end
    clr_cnt = 1'b1;
    push(edge_n + 1, 4'b1000, 4'b0, 4'b0, 4'b0, 32'h0, "clr_only");
    @(negedge clk);
    clr_cnt = 1'b0;
    while (q.size() != 0 && q[0].cyc == edge_n) begin
      e = q.pop_front();
      checks++;
      if ({clean, rise, fall, bounce} !== {e.cl, e.ri, e.fa, e.bo} ||
          bounce_cnt !== e.bc) begin
        errors++;
        $display("FAIL %s: got c=%b r=%b f=%b b=%b n=%h want c=%b r=%b f=%b b=%b n=%h",
                 e.tag, clean, rise, fall, bounce, bounce_cnt,
                 e.cl, e.ri, e.fa, e.bo, e.bc);
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sat_drain: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_burst();
    test_simultaneous();
    test_release();
    test_reset_mid_settle();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
